patch_trigger_ctrl: RTL and testbench

- Parametrised patch controller that sits on the instrumented ports of a patched module.
- Watches `observe_port` with NUM_TRIG programmable triggers. Each trigger is a mask/value match held for a set number of consecutive cycles.
- On firing, it overrides selected control bits between `control_port_in` and `control_port_out`, for a set number of cycles or until cleared.
- When no trigger is active it is a zero-latency pass-through, so an unprogrammed patch is functionally invisible.

---
 rtl/patch_pkg.sv | 25 ++
 rtl/patch_trigger_unit.sv | 164 ++++++++++++++++
 rtl/patch_trigger_ctrl.sv | 89 ++++++++
 tb/tb_patch_trigger_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/patch_pkg.sv
// Shared definitions for the patch trigger controller:
// register selects, trigger FSM states and CTRL register bit positions.
package patch_pkg;

  localparam logic [2:0] REG_MASK   = 3'd0;
  localparam logic [2:0] REG_VAL    = 3'd1;
  localparam logic [2:0] REG_THRESH = 3'd2;
  localparam logic [2:0] REG_HOLD   = 3'd3;
  localparam logic [2:0] REG_OMASK  = 3'd4;
  localparam logic [2:0] REG_OVAL   = 3'd5;
  localparam logic [2:0] REG_CTRL   = 3'd6;
  localparam logic [2:0] REG_STATUS = 3'd7;

  localparam int CTRL_ARM   = 0;
  localparam int CTRL_CLEAR = 1;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    FIRE    = 3'd2,
    HOLD_ST = 3'd3,
    STICKY  = 3'd4
  } state_e;

endpackage

// File: rtl/patch_trigger_unit.sv
// One programmable trigger: config registers, match counter,
// hold counter and the FSM that produces its override enable.
module patch_trigger_unit
  import patch_pkg::*;
#(
  parameter int NUM_CTRL = 8,
  parameter int NUM_OBS  = 5,
  parameter int CNT_W    = 8
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                we_i,
  input  logic [2:0]          sel_i,
  input  logic [31:0]         wdata_i,
  input  logic [NUM_OBS-1:0]  observe_i,
  output logic                active_o,
  output logic                sticky_o,
  output logic [NUM_CTRL-1:0] ovr_mask_o,
  output logic [NUM_CTRL-1:0] ovr_val_o,
  output logic [31:0]         rdata_o
);

  logic [NUM_OBS-1:0]  mmask_q, mmask_d;
  logic [NUM_OBS-1:0]  mval_q, mval_d;
  logic [CNT_W-1:0]    thr_q, thr_d;
  logic [CNT_W-1:0]    hcfg_q, hcfg_d;
  logic [NUM_CTRL-1:0] omask_q, omask_d;
  logic [NUM_CTRL-1:0] oval_q, oval_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CNT_W-1:0]    hold_q, hold_d;
  logic                sticky_q, sticky_d;
  state_e              state_q, state_d;

  logic             match;
  logic             arm;
  logic             clr;
  logic [CNT_W-1:0] thr_eff;
  logic [CNT_W-1:0] cnt_inc;
  logic             unused_wdata;

  assign unused_wdata = ^wdata_i;

  assign match   = (observe_i & mmask_q) == (mval_q & mmask_q);
  assign thr_eff = (thr_q == '0) ? CNT_W'(1) : thr_q;
  assign cnt_inc = cnt_q + CNT_W'(1);
  assign arm     = we_i && sel_i == REG_CTRL && wdata_i[CTRL_ARM];
  assign clr     = we_i && sel_i == REG_CTRL && wdata_i[CTRL_CLEAR];

  always_comb begin
    mmask_d  = mmask_q;
    mval_d   = mval_q;
    thr_d    = thr_q;
    hcfg_d   = hcfg_q;
    omask_d  = omask_q;
    oval_d   = oval_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    hold_d   = hold_q;
    sticky_d = sticky_q;
    if (we_i && state_q == IDLE) begin
      unique case (sel_i)
        REG_MASK:   mmask_d = wdata_i[NUM_OBS-1:0];
        REG_VAL:    mval_d  = wdata_i[NUM_OBS-1:0];
        REG_THRESH: thr_d   = wdata_i[CNT_W-1:0];
        REG_HOLD:   hcfg_d  = wdata_i[CNT_W-1:0];
        REG_OMASK:  omask_d = wdata_i[NUM_CTRL-1:0];
        REG_OVAL:   oval_d  = wdata_i[NUM_CTRL-1:0];
        default: ;
      endcase
    end
    unique case (state_q)
      IDLE: begin
        if (arm) begin
          state_d = ARMED;
          cnt_d   = '0;
        end
      end
      ARMED: begin
        if (!match) begin
          cnt_d = '0;
        end else if (cnt_inc == thr_eff) begin
          state_d = FIRE;
          cnt_d   = cnt_inc;
          hold_d  = hcfg_q;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      // FIRE is the first override cycle, so it consumes one hold count
      FIRE: begin
        sticky_d = 1'b1;
        if (hcfg_q == '0) begin
          state_d = STICKY;
        end else if (hold_q == CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          state_d = HOLD_ST;
          hold_d  = hold_q - CNT_W'(1);
        end
      end
      HOLD_ST: begin
        if (hold_q <= CNT_W'(1)) begin
          state_d = IDLE;
        end else begin
          hold_d = hold_q - CNT_W'(1);
        end
      end
      STICKY: ;
      default: state_d = IDLE;
    endcase
    if (clr) begin
      state_d  = IDLE;
      cnt_d    = '0;
      hold_d   = '0;
      sticky_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mmask_q  <= '0;
      mval_q   <= '0;
      thr_q    <= '0;
      hcfg_q   <= '0;
      omask_q  <= '0;
      oval_q   <= '0;
      state_q  <= IDLE;
      cnt_q    <= '0;
      hold_q   <= '0;
      sticky_q <= 1'b0;
    end else begin
      mmask_q  <= mmask_d;
      mval_q   <= mval_d;
      thr_q    <= thr_d;
      hcfg_q   <= hcfg_d;
      omask_q  <= omask_d;
      oval_q   <= oval_d;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hold_q   <= hold_d;
      sticky_q <= sticky_d;
    end
  end

  assign active_o   = state_q == FIRE || state_q == HOLD_ST || state_q == STICKY;
  assign sticky_o   = sticky_q;
  assign ovr_mask_o = omask_q;
  assign ovr_val_o  = oval_q;

  always_comb begin
    rdata_o = '0;
    unique case (sel_i)
      REG_MASK:   rdata_o = 32'(mmask_q);
      REG_VAL:    rdata_o = 32'(mval_q);
      REG_THRESH: rdata_o = 32'(thr_q);
      REG_HOLD:   rdata_o = 32'(hcfg_q);
      REG_OMASK:  rdata_o = 32'(omask_q);
      REG_OVAL:   rdata_o = 32'(oval_q);
      REG_STATUS: rdata_o = {15'd0, sticky_q, 8'(cnt_q), 5'd0, state_q};
      default:    rdata_o = '0;
    endcase
  end

endmodule

// File: rtl/patch_trigger_ctrl.sv
// Patch controller top: config decode, read mux, priority merge of
// trigger overrides onto the control path, and the irq register.
module patch_trigger_ctrl
  import patch_pkg::*;
#(
  parameter int NUM_CTRL = 8,
  parameter int NUM_OBS  = 5,
  parameter int NUM_TRIG = 2,
  parameter int CNT_W    = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_OBS-1:0]            observe_port,
  input  logic [NUM_CTRL-1:0]           control_port_in,
  output logic [NUM_CTRL-1:0]           control_port_out,
  input  logic                          cfg_we,
  input  logic [2+$clog2(NUM_TRIG):0]   cfg_addr,
  input  logic [31:0]                   cfg_wdata,
  output logic [31:0]                   cfg_rdata,
  output logic [NUM_TRIG-1:0]           trig_fired,
  output logic                          irq
);

  logic [31:0]         idx;
  logic [2:0]          sel;
  logic [NUM_TRIG-1:0] active;
  logic [NUM_TRIG-1:0] sticky;
  logic [NUM_CTRL-1:0] omask [NUM_TRIG];
  logic [NUM_CTRL-1:0] oval  [NUM_TRIG];
  logic [31:0]         rd_u  [NUM_TRIG];
  logic                irq_q;

  assign sel = cfg_addr[2:0];

  generate
    if (NUM_TRIG > 1) begin : g_idx
      assign idx = 32'(cfg_addr[2+$clog2(NUM_TRIG):3]);
    end else begin : g_idx1
      assign idx = '0;
    end
  endgenerate

  for (genvar i = 0; i < NUM_TRIG; i++) begin : g_trig
    patch_trigger_unit #(
      .NUM_CTRL (NUM_CTRL),
      .NUM_OBS  (NUM_OBS),
      .CNT_W    (CNT_W)
    ) u_unit (
      .clk_i      (clk),
      .rst_i      (rst),
      .we_i       (cfg_we && idx == 32'(i)),
      .sel_i      (sel),
      .wdata_i    (cfg_wdata),
      .observe_i  (observe_port),
      .active_o   (active[i]),
      .sticky_o   (sticky[i]),
      .ovr_mask_o (omask[i]),
      .ovr_val_o  (oval[i]),
      .rdata_o    (rd_u[i])
    );
  end

  // Applied highest index first so the lowest active index lands last
  always_comb begin
    control_port_out = control_port_in;
    for (int i = NUM_TRIG - 1; i >= 0; i--) begin
      if (active[i]) begin
        control_port_out = (control_port_out & ~omask[i])
                         | (oval[i] & omask[i]);
      end
    end
  end

  always_comb begin
    cfg_rdata = '0;
    for (int i = 0; i < NUM_TRIG; i++) begin
      if (idx == 32'(i)) cfg_rdata = rd_u[i];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) irq_q <= 1'b0;
    else     irq_q <= |sticky;
  end

  assign irq        = irq_q;
  assign trig_fired = active;

endmodule

// File: tb/tb_patch_trigger_ctrl.sv
// Directed bench for patch_trigger_ctrl: pass-through, hold window,
// miss restart, sticky/clear, priority overlap, IDLE-only writes, reset.
module tb_patch_trigger_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  obs;
  logic [7:0]  cin;
  logic [7:0]  cout;
  logic        we;
  logic [3:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [1:0]  fired;
  logic        irq;
  logic [31:0] r;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  patch_trigger_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .observe_port     (obs),
    .control_port_in  (cin),
    .control_port_out (cout),
    .cfg_we           (we),
    .cfg_addr         (addr),
    .cfg_wdata        (wdata),
    .cfg_rdata        (rdata),
    .trig_fired       (fired),
    .irq              (irq)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic wr(input logic idx, input logic [2:0] sel,
                    input logic [31:0] d);
    addr  = {idx, sel};
    wdata = d;
    we    = 1'b1;
    @(posedge clk);
    #2;
    we    = 1'b0;
    wdata = '0;
  endtask

  task automatic rd(input logic idx, input logic [2:0] sel,
                    output logic [31:0] d);
    we   = 1'b0;
    addr = {idx, sel};
    #1;
    d = rdata;
  endtask

  initial begin
    rst   = 1'b1;
    obs   = '0;
    cin   = 8'hA5;
    we    = 1'b0;
    addr  = '0;
    wdata = '0;
    #3;
    chk("rst_pass", 32'(cout), 32'h0000_00A5);
    tick();
    tick();
    rst = 1'b0;
    tick();
    cin = 8'h5A;
    #1;
    chk("idle_pass", 32'(cout), 32'h0000_005A);
    chk("idle_fired", 32'(fired), 32'h0);
    chk("idle_irq", 32'(irq), 32'h0);

    // trigger 0: hold window of 4 cycles
    wr(1'b0, 3'd0, 32'h03);
    wr(1'b0, 3'd1, 32'hFFFF_FFE1);
    wr(1'b0, 3'd2, 32'd3);
    wr(1'b0, 3'd3, 32'd4);
    wr(1'b0, 3'd4, 32'h0F);
    wr(1'b0, 3'd5, 32'h00);
    rd(1'b0, 3'd1, r);
    chk("val_trunc", r, 32'h01);
    wr(1'b0, 3'd6, 32'h1);
    obs = 5'b10101;
    cin = 8'hFF;
    #1;
    chk("armed_pass", 32'(cout), 32'hFF);
    for (int k = 1; k <= 7; k++) begin
      tick();
      chk($sformatf("hold4_c%0d", k), 32'(cout),
          (k >= 3 && k <= 6) ? 32'hF0 : 32'hFF);
      if (k == 3) chk("hold4_fired", 32'(fired), 32'h1);
    end
    chk("hold4_irq", 32'(irq), 32'h1);
    chk("hold4_done_fired", 32'(fired), 32'h0);
    rd(1'b0, 3'd7, r);
    chk("hold4_status", r, 32'h0001_0300);

    // match, match, miss, match x3
    wr(1'b0, 3'd6, 32'h1);
    obs = 5'b00001;
    tick();
    tick();
    obs = 5'b00000;
    tick();
    rd(1'b0, 3'd7, r);
    chk("miss_status", r, 32'h0001_0001);
    obs = 5'b00001;
    tick();
    tick();
    chk("miss_nofire", 32'(cout), 32'hFF);
    tick();
    chk("miss_fire", 32'(cout), 32'hF0);
    wr(1'b0, 3'd6, 32'h2);
    obs = 5'b00000;
    #1;
    chk("miss_clr_pass", 32'(cout), 32'hFF);
    rd(1'b0, 3'd7, r);
    chk("miss_clr_status", r, 32'h0);

    // HOLD=0: sticky override until CLEAR
    wr(1'b0, 3'd3, 32'd0);
    wr(1'b0, 3'd6, 32'h1);
    obs = 5'b00001;
    repeat (3) tick();
    chk("sticky_first", 32'(cout), 32'hF0);
    repeat (120) tick();
    chk("sticky_long", 32'(cout), 32'hF0);
    chk("sticky_fired", 32'(fired), 32'h1);
    chk("sticky_irq", 32'(irq), 32'h1);
    rd(1'b0, 3'd7, r);
    chk("sticky_status", r, 32'h0001_0304);
    wr(1'b0, 3'd6, 32'h3);
    chk("clr_pass", 32'(cout), 32'hFF);
    chk("clr_fired", 32'(fired), 32'h0);
    tick();
    chk("clr_irq", 32'(irq), 32'h0);
    rd(1'b0, 3'd7, r);
    chk("clr_status", r, 32'h0);

    // overlap: trigger 0 beats trigger 1 on bit 0
    wr(1'b0, 3'd4, 32'h01);
    wr(1'b0, 3'd5, 32'h00);
    wr(1'b0, 3'd2, 32'd0);
    wr(1'b1, 3'd4, 32'h03);
    wr(1'b1, 3'd5, 32'h03);
    wr(1'b1, 3'd6, 32'h1);
    wr(1'b0, 3'd6, 32'h1);
    tick();
    cin = 8'h00;
    #1;
    chk("ovl_00", 32'(cout), 32'h02);
    chk("ovl_fired", 32'(fired), 32'h3);
    cin = 8'hFF;
    #1;
    chk("ovl_ff", 32'(cout), 32'hFE);

    // config writes dropped outside IDLE
    wr(1'b0, 3'd6, 32'h2);
    wr(1'b1, 3'd6, 32'h2);
    wr(1'b1, 3'd0, 32'h1F);
    wr(1'b1, 3'd1, 32'h1F);
    wr(1'b1, 3'd6, 32'h1);
    wr(1'b1, 3'd1, 32'h0A);
    rd(1'b1, 3'd1, r);
    chk("armed_val_kept", r, 32'h1F);
    rd(1'b1, 3'd7, r);
    chk("armed_status", r, 32'h1);
    chk("armed_cout", 32'(cout), 32'hFF);

    // reset in the middle of a hold window
    wr(1'b0, 3'd2, 32'd3);
    wr(1'b0, 3'd3, 32'd4);
    wr(1'b0, 3'd4, 32'h0F);
    wr(1'b0, 3'd6, 32'h1);
    repeat (4) tick();
    chk("rst_pre_cout", 32'(cout), 32'hF0);
    rd(1'b0, 3'd7, r);
    chk("rst_pre_status", r, 32'h0001_0303);
    rst = 1'b1;
    #1;
    chk("rst_mid_cout", 32'(cout), 32'hFF);
    chk("rst_mid_fired", 32'(fired), 32'h0);
    chk("rst_mid_irq", 32'(irq), 32'h0);
    rd(1'b0, 3'd0, r);
    chk("rst_mask0", r, 32'h0);
    rd(1'b0, 3'd3, r);
    chk("rst_hold0", r, 32'h0);
    rd(1'b1, 3'd1, r);
    chk("rst_val1", r, 32'h0);
    rd(1'b1, 3'd7, r);
    chk("rst_status1", r, 32'h0);
    tick();
    rst = 1'b0;
    tick();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
